// File: rtl/icache_direct_mapped_pkg.sv
// rtl/icache_direct_mapped_pkg.sv - shared field widths, FSM encodings and word select helper
package icache_direct_mapped_pkg;

    localparam int ADDR_W       = 32;
    localparam int OFFSET_W     = 4;
    localparam int BLOCK_ADDR_W = ADDR_W - OFFSET_W;
    localparam int BLOCK_W      = 128;
    localparam int WORD_W       = 32;
    localparam int WORD_SEL_LSB = 2;
    localparam int WORD_SEL_W   = 2;

    localparam logic [1:0] STATE_IDLE     = 2'd0;
    localparam logic [1:0] STATE_MEM_READ = 2'd1;
    localparam logic [1:0] STATE_UPDATE   = 2'd2;

    function automatic logic [WORD_W-1:0] select_word(
        input logic [BLOCK_W-1:0]    block,
        input logic [WORD_SEL_W-1:0] sel
    );
        return block[WORD_W*sel +: WORD_W];
    endfunction

endpackage

// File: rtl/icache_direct_mapped_line_array.sv
// rtl/icache_direct_mapped_line_array.sv - tag/valid/data storage, one comb read port, one write port
module icache_line_array
    import icache_direct_mapped_pkg::*;
#(
    parameter int INDEX_W = 3,
    parameter int TAG_W   = 28 - INDEX_W
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [INDEX_W-1:0] rd_index,
    output logic               rd_valid,
    output logic [TAG_W-1:0]   rd_tag,
    output logic [BLOCK_W-1:0] rd_data,
    input  logic               wr_en,
    input  logic [INDEX_W-1:0] wr_index,
    input  logic [TAG_W-1:0]   wr_tag,
    input  logic [BLOCK_W-1:0] wr_data
);

    localparam int LINES = 1 << INDEX_W;

    logic [LINES-1:0]   valid_q, valid_d;
    logic [TAG_W-1:0]   tag_q  [LINES];
    logic [TAG_W-1:0]   tag_d  [LINES];
    logic [BLOCK_W-1:0] data_q [LINES];
    logic [BLOCK_W-1:0] data_d [LINES];

    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (wr_en) begin
            valid_d[wr_index] = 1'b1;
            tag_d[wr_index]   = wr_tag;
            data_d[wr_index]  = wr_data;
        end
    end

    // Only valid bits are reset; stale tag/data are harmless while their line is invalid.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge clock) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

    assign rd_valid = valid_q[rd_index];
    assign rd_tag   = tag_q[rd_index];
    assign rd_data  = data_q[rd_index];

endmodule

// File: rtl/icache_direct_mapped.sv
// rtl/icache_direct_mapped.sv - direct-mapped read-only instruction cache with block refill FSM
module icache_direct_mapped
    import icache_direct_mapped_pkg::*;
#(
    parameter int INDEX_W = 3
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    cpu_read,
    input  logic [ADDR_W-1:0]       cpu_address,
    output logic [WORD_W-1:0]       cpu_instruction,
    output logic                    cpu_busywait,
    output logic                    mem_read,
    output logic [BLOCK_ADDR_W-1:0] mem_address,
    input  logic [BLOCK_W-1:0]      mem_readdata,
    input  logic                    mem_busywait
);

    localparam int TAG_W = BLOCK_ADDR_W - INDEX_W;

    logic [1:0]              state_q, state_d;
    logic [BLOCK_ADDR_W-1:0] miss_addr_q, miss_addr_d;
    logic                    seen_busy_q, seen_busy_d;

    logic [INDEX_W-1:0]    cpu_index;
    logic [TAG_W-1:0]      cpu_tag;
    logic [WORD_SEL_W-1:0] cpu_word;
    logic                  rd_valid;
    logic [TAG_W-1:0]      rd_tag;
    logic [BLOCK_W-1:0]    rd_data;
    logic                  wr_en;
    logic                  hit;
    logic                  unused_byte_offset;

    assign cpu_index          = cpu_address[OFFSET_W +: INDEX_W];
    assign cpu_tag            = cpu_address[ADDR_W-1 -: TAG_W];
    assign cpu_word           = cpu_address[WORD_SEL_LSB +: WORD_SEL_W];
    assign unused_byte_offset = &{1'b0, cpu_address[1:0]};

    icache_line_array #(
        .INDEX_W (INDEX_W),
        .TAG_W   (TAG_W)
    ) u_line_array (
        .clock    (clock),
        .reset    (reset),
        .rd_index (cpu_index),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data),
        .wr_en    (wr_en),
        .wr_index (miss_addr_q[INDEX_W-1:0]),
        .wr_tag   (miss_addr_q[BLOCK_ADDR_W-1:INDEX_W]),
        .wr_data  (mem_readdata)
    );

    assign hit             = cpu_read & rd_valid & (rd_tag == cpu_tag);
    assign cpu_instruction = hit ? select_word(rd_data, cpu_word) : '0;
    assign cpu_busywait    = (state_q != STATE_IDLE) | (cpu_read & ~hit);
    assign mem_read        = (state_q == STATE_MEM_READ);
    assign mem_address     = miss_addr_q;

    // Memory may hold busywait low for a cycle or two after mem_read rises, so
    // completion only counts once busy has actually been observed.
    always_comb begin
        state_d     = state_q;
        miss_addr_d = miss_addr_q;
        seen_busy_d = seen_busy_q;
        wr_en       = 1'b0;
        case (state_q)
            STATE_IDLE: begin
                if (cpu_read && !hit) begin
                    miss_addr_d = cpu_address[ADDR_W-1:OFFSET_W];
                    seen_busy_d = 1'b0;
                    state_d     = STATE_MEM_READ;
                end
            end
            STATE_MEM_READ: begin
                if (mem_busywait) begin
                    seen_busy_d = 1'b1;
                end else if (seen_busy_q) begin
                    wr_en   = 1'b1;
                    state_d = STATE_UPDATE;
                end
            end
            STATE_UPDATE: begin
                state_d = STATE_IDLE;
            end
            default: begin
                state_d = STATE_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= STATE_IDLE;
            miss_addr_q <= '0;
            seen_busy_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            miss_addr_q <= miss_addr_d;
            seen_busy_q <= seen_busy_d;
        end
    end

endmodule
